// File: rtl/pcpi_initiator.sv
// pcpi_initiator: host-side PCPI master issuing one custom instruction at a time,
// returning the result, write flag, status and latency on a valid/ready response port.
module pcpi_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_insn,
    input  logic [31:0]      cmd_rs1,
    input  logic [31:0]      cmd_rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_wr,
    output logic [1:0]       rsp_status,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [31:0]      pcpi_rs1,
    output logic [31:0]      pcpi_rs2,
    input  logic             pcpi_wr,
    input  logic [31:0]      pcpi_rd,
    input  logic             pcpi_wait,
    input  logic             pcpi_ready
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]       insn_q, insn_d;
    logic [31:0]       rs1_q, rs1_d;
    logic [31:0]       rs2_q, rs2_d;
    logic [31:0]       data_q, data_d;
    logic              wr_q, wr_d;
    logic [1:0]        status_q, status_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            status_q <= 2'b00;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            insn_q   <= insn_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            status_q <= status_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        insn_d   = insn_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        data_d   = data_q;
        wr_d     = wr_q;
        status_d = status_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    insn_d   = cmd_insn;
                    rs1_d    = cmd_rs1;
                    rs2_d    = cmd_rs2;
                    to_cnt_d = '0;
                    cycles_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
                // ready wins over wait, and wait wins over an expiring timeout
                if (pcpi_ready) begin
                    data_d   = pcpi_rd;
                    wr_d     = pcpi_wr;
                    status_d = 2'b00;
                    state_d  = RESP;
                end else if (pcpi_wait) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    data_d   = '0;
                    wr_d     = 1'b0;
                    status_d = 2'b01;
                    state_d  = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign pcpi_valid = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign rsp_data   = data_q;
    assign rsp_wr     = wr_q;
    assign rsp_status = status_q;
    assign rsp_cycles = cycles_q;
endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator: directed checks of the PCPI initiator with a switchable
// combinational XOR responder and manually driven responder handshakes.
module tb_pcpi_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_cycles;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;

    logic        comb_en, ready_m, wr_m, wait_m;
    logic [31:0] rd_m;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n;

    always #5 clk = ~clk;

    assign pcpi_ready = comb_en ? pcpi_valid : ready_m;
    assign pcpi_rd    = comb_en ? (pcpi_rs1 ^ pcpi_rs2) : rd_m;
    assign pcpi_wr    = comb_en ? 1'b1 : wr_m;
    assign pcpi_wait  = comb_en ? 1'b0 : wait_m;

    pcpi_initiator #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; returns in the first ISSUE cycle.
    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        cmd_valid = 1'b1;
        cmd_insn  = insn;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        chk("issue_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("issue_pcpi_valid", 64'(pcpi_valid), 64'd1);
        chk("issue_pcpi_insn", 64'(pcpi_insn), 64'(insn));
        chk("issue_pcpi_rs1", 64'(pcpi_rs1), 64'(rs1));
        chk("issue_pcpi_rs2", 64'(pcpi_rs2), 64'(rs2));
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ack_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("ack_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        rsp_ready = 1'b0; comb_en = 1'b0; ready_m = 1'b0; wr_m = 1'b0; wait_m = 1'b0; rd_m = '0;
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_pcpi_valid", 64'(pcpi_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_cycles", 64'(rsp_cycles), 64'd0);
        chk("rst_pcpi_insn", 64'(pcpi_insn), 64'd0);
        rst = 1'b1;
        tick();

        // 1: combinational XOR responder
        comb_en = 1'b1;
        issue(32'h0000_000b, 32'hffff_0000, 32'h5555_5555);
        chk("t1_rsp_valid_early", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_data", 64'(rsp_data), 64'haaaa_5555);
        chk("t1_rsp_wr", 64'(rsp_wr), 64'd1);
        chk("t1_status", 64'(rsp_status), 64'd0);
        chk("t1_cycles", 64'(rsp_cycles), 64'd1);
        chk("t1_pcpi_valid", 64'(pcpi_valid), 64'd0);
        ack();
        comb_en = 1'b0;

        // 2: no responder -> timeout after 16 cycles
        issue(32'h0000_100b, 32'h1, 32'h2);
        n = 0;
        while (pcpi_valid === 1'b1 && n < 100) begin n++; tick(); end
        chk("t2_valid_cycles", 64'(n), 64'd16);
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_data", 64'(rsp_data), 64'd0);
        chk("t2_rsp_wr", 64'(rsp_wr), 64'd0);
        chk("t2_status", 64'(rsp_status), 64'd1);
        chk("t2_cycles", 64'(rsp_cycles), 64'd16);
        ack();

        // 3: wait held 40 cycles, then ready
        wait_m = 1'b1;
        issue(32'h0000_200b, 32'h3, 32'h4);
        for (int i = 0; i < 40; i++) tick();
        chk("t3_still_issue", 64'(pcpi_valid), 64'd1);
        wait_m = 1'b0; ready_m = 1'b1; rd_m = 32'h1234_5678; wr_m = 1'b1;
        tick();
        ready_m = 1'b0;
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t3_status", 64'(rsp_status), 64'd0);
        chk("t3_rsp_data", 64'(rsp_data), 64'h1234_5678);
        chk("t3_rsp_wr", 64'(rsp_wr), 64'd1);
        chk("t3_cycles", 64'(rsp_cycles), 64'd41);
        ack();

        // 4: held response ignores stray pcpi_ready and cmd_valid
        ready_m = 1'b1; rd_m = 32'h0000_0002; wr_m = 1'b0;
        issue(32'h0000_300b, 32'h1, 32'h3);
        tick();
        rd_m = 32'hdead_beef; wr_m = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("t4_rsp_data", 64'(rsp_data), 64'h2);
            chk("t4_rsp_wr", 64'(rsp_wr), 64'd0);
            chk("t4_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("t4_pcpi_valid", 64'(pcpi_valid), 64'd0);
            tick();
        end
        cmd_valid = 1'b0;
        ack();
        tick();
        chk("t4_idle_stray_ready", 64'(cmd_ready), 64'd1);
        chk("t4_idle_no_rsp", 64'(rsp_valid), 64'd0);
        ready_m = 1'b0; wr_m = 1'b0;

        // 5: ready coincides with the timeout cycle
        issue(32'h0000_400b, 32'h5, 32'h6);
        for (int i = 0; i < 15; i++) tick();
        chk("t5_still_issue", 64'(pcpi_valid), 64'd1);
        ready_m = 1'b1; rd_m = 32'hcafe_f00d; wr_m = 1'b1;
        tick();
        ready_m = 1'b0;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t5_status", 64'(rsp_status), 64'd0);
        chk("t5_rsp_data", 64'(rsp_data), 64'hcafe_f00d);
        chk("t5_cycles", 64'(rsp_cycles), 64'd16);
        ack();

        // 6: reset mid-ISSUE, then a normal op
        issue(32'h0000_500b, 32'h7, 32'h8);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_pcpi_valid", 64'(pcpi_valid), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t6_cycles", 64'(rsp_cycles), 64'd0);
        comb_en = 1'b1;
        issue(32'h0000_600b, 32'h1234_0000, 32'h0000_5678);
        tick();
        chk("t6_rsp_valid2", 64'(rsp_valid), 64'd1);
        chk("t6_rsp_data", 64'(rsp_data), 64'h1234_5678);
        chk("t6_status", 64'(rsp_status), 64'd0);
        chk("t6_cycles2", 64'(rsp_cycles), 64'd1);
        ack();
        comb_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
